// File: rtl/result_buf_pkg.sv
// Shared register map and bit positions for the AXI-Stream to Wishbone result buffer.
package result_buf_pkg;

    localparam logic [7:0] OFS_STATUS = 8'h00;
    localparam logic [7:0] OFS_DATA   = 8'h04;
    localparam logic [7:0] OFS_CTRL   = 8'h08;

    localparam int ST_COUNT_W   = 7;
    localparam int ST_EMPTY     = 8;
    localparam int ST_FULL      = 9;
    localparam int ST_DONE      = 10;
    localparam int ST_UNDERFLOW = 11;
    localparam int ST_LAST_HEAD = 12;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_CLR_UF = 1;

    typedef enum logic [1:0] {
        REG_STATUS,
        REG_DATA,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_e;

    function automatic reg_sel_e decode_reg(input logic [5:0] word_idx);
        if (word_idx == OFS_STATUS[7:2])    return REG_STATUS;
        else if (word_idx == OFS_DATA[7:2]) return REG_DATA;
        else if (word_idx == OFS_CTRL[7:2]) return REG_CTRL;
        else                                return REG_NONE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with head-of-queue read and synchronous flush; storage is not reset.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/axis_wb_result_buf.sv
// Buffers engine result beats from AXI-Stream and exposes them to a Wishbone master
// through STATUS / DATA (popping) / CTRL registers.
module axis_wb_result_buf
    import result_buf_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    bus_state_e state_q;
    logic       ack_q;
    logic [31:0] dat_q;
    logic       done_q, done_d;
    logic       underflow_q, underflow_d;

    logic                   req;
    reg_sel_e               sel;
    logic                   pop, push, flush_now, clr_uf, uf_set;
    logic [pDATA_WIDTH:0]   head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full, fifo_empty;
    logic [31:0]            status_word;
    logic [31:0]            rd_mux;
    logic                   unused_bits;

    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i[31:2]};

    // Side effects happen only in the IDLE sampling cycle, so each request acts once.
    always_comb begin
        req       = (state_q == BUS_IDLE) && wbs_cyc_i && wbs_stb_i;
        sel       = decode_reg(wbs_adr_i[7:2]);
        pop       = req && !wbs_we_i && (sel == REG_DATA) && !fifo_empty;
        uf_set    = req && !wbs_we_i && (sel == REG_DATA) && fifo_empty;
        flush_now = req && wbs_we_i && (sel == REG_CTRL) && wbs_dat_i[CTRL_FLUSH];
        clr_uf    = req && wbs_we_i && (sel == REG_CTRL)
                    && (wbs_dat_i[CTRL_FLUSH] || wbs_dat_i[CTRL_CLR_UF]);
        s_tready  = !fifo_full && !flush_now;
        push      = s_tvalid && s_tready;
    end

    sync_fifo #(
        .WIDTH (pDATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_now),
        .push  (push),
        .pop   (pop),
        .wdata ({s_tlast, s_tdata}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_word                   = '0;
        status_word[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
        status_word[ST_EMPTY]         = fifo_empty;
        status_word[ST_FULL]          = fifo_full;
        status_word[ST_DONE]          = done_q;
        status_word[ST_UNDERFLOW]     = underflow_q;
        // Head entry is stale storage when empty, so gate its tlast.
        status_word[ST_LAST_HEAD]     = !fifo_empty && head[pDATA_WIDTH];

        rd_mux = '0;
        if (!wbs_we_i) begin
            case (sel)
                REG_STATUS: rd_mux = status_word;
                REG_DATA:   rd_mux = fifo_empty ? '0 : 32'(head[pDATA_WIDTH-1:0]);
                default:    rd_mux = '0;
            endcase
        end

        done_d = done_q;
        if (flush_now)               done_d = 1'b0;
        else if (push && s_tlast)    done_d = 1'b1;

        underflow_d = underflow_q;
        if (clr_uf)      underflow_d = 1'b0;
        else if (uf_set) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                BUS_IDLE: begin
                    if (req) begin
                        state_q <= BUS_ACK;
                        ack_q   <= 1'b1;
                        dat_q   <= rd_mux;
                    end
                end
                default: begin
                    state_q <= BUS_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_axis_wb_result_buf.sv
// Directed bench for axis_wb_result_buf: stream pushes, register reads/writes, flush and reset.
module tb_axis_wb_result_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_wb_result_buf #(.pDATA_WIDTH(32), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .s_tdata   (s_tdata),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o)
    );

    // Starts and ends 1 time unit after a rising edge with the bus FSM idle.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             output logic [31:0] rdat, output int lat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wbs_ack_o && lat < 8);
        rdat = wbs_ack_o ? wbs_dat_o : 32'hxxxx_xxxx;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic l);
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; int lat;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (wbs_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", wbs_ack_o); end
        total++; if (wbs_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", wbs_dat_o); end
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b exp=1", s_tready); end
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h100) begin bad++; $display("FAIL reset_status got=%h exp=00000100", r); end
        wb_access(1'b0, 32'h10, 32'h0, r, lat);
        total++; if (r !== 32'h0 || lat != 1) begin bad++; $display("FAIL unmapped_read got=%h lat=%0d exp=0 lat=1", r, lat); end
    endtask

    task automatic test_basic();
        logic [31:0] r; int lat;
        push_beat(32'h11, 1'b0);
        push_beat(32'h22, 1'b0);
        push_beat(32'h33, 1'b1);
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h403) begin bad++; $display("FAIL basic_status3 got=%h exp=00000403", r); end
        wb_access(1'b0, 32'h4, 32'h0, r, lat);
        total++; if (r !== 32'h11) begin bad++; $display("FAIL basic_rd0 got=%h exp=00000011", r); end
        wb_access(1'b0, 32'h4, 32'h0, r, lat);
        total++; if (r !== 32'h22) begin bad++; $display("FAIL basic_rd1 got=%h exp=00000022", r); end
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h1401) begin bad++; $display("FAIL basic_status_last got=%h exp=00001401", r); end
        wb_access(1'b0, 32'h4, 32'h0, r, lat);
        total++; if (r !== 32'h33) begin bad++; $display("FAIL basic_rd2 got=%h exp=00000033", r); end
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h500) begin bad++; $display("FAIL basic_status_empty got=%h exp=00000500", r); end
        wb_access(1'b1, 32'h8, 32'h1, r, lat);
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h100) begin bad++; $display("FAIL basic_flushed got=%h exp=00000100", r); end
    endtask

    task automatic test_fill();
        logic [31:0] r; int lat; int accepted; logic rdy [20];
        accepted = 0;
        s_tvalid = 1'b1; s_tlast = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_tdata = 32'h100 + i;
            #1;
            rdy[i] = s_tready;
            if (s_tready) accepted++;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        total++; if (accepted != 16) begin bad++; $display("FAIL fill_accepted got=%0d exp=16", accepted); end
        total++; if (rdy[15] !== 1'b1 || rdy[16] !== 1'b0) begin bad++; $display("FAIL fill_tready15_16 got=%b%b exp=10", rdy[15], rdy[16]); end
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h210) begin bad++; $display("FAIL fill_status got=%h exp=00000210", r); end
        // Pop from full while a beat is offered: tready must stay low in that cycle.
        s_tvalid = 1'b1; s_tdata = 32'hDEAD;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4;
        #1;
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL full_pop_tready got=%b exp=0", s_tready); end
        @(posedge clk); #1;
        total++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h100) begin bad++; $display("FAIL full_pop_data ack=%b got=%h exp=00000100", wbs_ack_o, wbs_dat_o); end
        s_tvalid = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h00F) begin bad++; $display("FAIL full_pop_status got=%h exp=0000000f", r); end
        wb_access(1'b1, 32'h8, 32'h1, r, lat);
    endtask

    task automatic test_underflow();
        logic [31:0] r; int lat;
        wb_access(1'b0, 32'h4, 32'h0, r, lat);
        total++; if (r !== 32'h0 || lat != 1) begin bad++; $display("FAIL uf_read got=%h lat=%0d exp=0 lat=1", r, lat); end
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h900) begin bad++; $display("FAIL uf_status got=%h exp=00000900", r); end
        wb_access(1'b1, 32'h0, 32'h1, r, lat);
        wb_access(1'b1, 32'h8, 32'h2, r, lat);
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h100) begin bad++; $display("FAIL uf_cleared got=%h exp=00000100", r); end
    endtask

    task automatic test_push_pop();
        logic [31:0] r; int lat;
        for (int i = 0; i < 5; i++) push_beat(32'hA0 + i, 1'b0);
        s_tvalid = 1'b1; s_tdata = 32'hA5; s_tlast = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4;
        @(posedge clk); #1;
        s_tvalid = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        total++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hA0) begin bad++; $display("FAIL pp_first ack=%b got=%h exp=000000a0", wbs_ack_o, wbs_dat_o); end
        @(posedge clk); #1;
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h005) begin bad++; $display("FAIL pp_count got=%h exp=00000005", r); end
        for (int i = 1; i <= 5; i++) begin
            wb_access(1'b0, 32'h4, 32'h0, r, lat);
            total++; if (r !== 32'hA0 + i) begin bad++; $display("FAIL pp_order%0d got=%h exp=%h", i, r, 32'hA0 + i); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat;
        push_beat(32'h55, 1'b0);
        push_beat(32'h66, 1'b0);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4;
        @(posedge clk); #1;
        total++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h55) begin bad++; $display("FAIL b2b_c1 ack=%b got=%h exp=1/00000055", wbs_ack_o, wbs_dat_o); end
        @(posedge clk); #1;
        total++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h55) begin bad++; $display("FAIL b2b_c2 ack=%b got=%h exp=0/00000055", wbs_ack_o, wbs_dat_o); end
        @(posedge clk); #1;
        total++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h66) begin bad++; $display("FAIL b2b_c3 ack=%b got=%h exp=1/00000066", wbs_ack_o, wbs_dat_o); end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        total++; if (wbs_ack_o !== 1'b0) begin bad++; $display("FAIL b2b_c4 ack=%b exp=0", wbs_ack_o); end
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h100) begin bad++; $display("FAIL b2b_status got=%h exp=00000100", r); end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat;
        for (int i = 0; i < 10; i++) push_beat(32'hC0 + i, (i == 9));
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h40A) begin bad++; $display("FAIL fl_status10 got=%h exp=0000040a", r); end
        s_tvalid = 1'b1; s_tdata = 32'hBEEF; s_tlast = 1'b1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 32'h8; wbs_dat_i = 32'h1;
        #1;
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL fl_tready got=%b exp=0", s_tready); end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h100) begin bad++; $display("FAIL fl_status0 got=%h exp=00000100", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat;
        for (int i = 1; i <= 4; i++) push_beat(i, 1'b0);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4;
        @(posedge clk); #1;
        total++; if (wbs_ack_o !== 1'b1) begin bad++; $display("FAIL rm_ack_before got=%b exp=1", wbs_ack_o); end
        rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        total++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin bad++; $display("FAIL rm_ack_dropped ack=%b dat=%h exp=0/0", wbs_ack_o, wbs_dat_o); end
        rst = 1'b0;
        #1;
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL rm_tready got=%b exp=1", s_tready); end
        @(posedge clk); #1;
        wb_access(1'b0, 32'h0, 32'h0, r, lat);
        total++; if (r !== 32'h100) begin bad++; $display("FAIL rm_status got=%h exp=00000100", r); end
    endtask

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = '0; wbs_dat_i = '0;
        test_reset();
        test_basic();
        test_fill();
        test_underflow();
        test_push_pop();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
